// File: rtl/tank_pkg.sv
// Shared state type, default key codes and screen bounds for the tank controller.
package tank_pkg;

    typedef enum logic [1:0] {
        StAlive    = 2'd0,
        StDead     = 2'd1,
        StGameOver = 2'd2
    } tank_state_e;

    localparam logic [7:0] KEY_FWD_DEF  = 8'h52;
    localparam logic [7:0] KEY_REV_DEF  = 8'h51;
    localparam logic [7:0] KEY_CCW_DEF  = 8'h50;
    localparam logic [7:0] KEY_CW_DEF   = 8'h4f;
    localparam logic [7:0] KEY_FIRE_DEF = 8'h2c;

    localparam logic [9:0] SCREEN_W = 10'd640;
    localparam logic [9:0] SCREEN_H = 10'd480;

    // Sign-magnitude (sign bit + 8-bit magnitude) to 10-bit two's complement.
    function automatic logic [9:0] sm_to_tc(input logic neg, input logic [7:0] mag);
        logic [9:0] v;
        v = {2'b00, mag};
        return neg ? (~v + 10'd1) : v;
    endfunction

endpackage

// File: rtl/tank_step_calc.sv
// Combinational per-frame displacement from the sign-magnitude heading and speed.
module tank_step_calc
    import tank_pkg::*;
(
    input  logic [7:0] i_sin,
    input  logic [7:0] i_cos,
    input  logic [7:0] i_step_q,
    input  logic       i_fwd,
    input  logic       i_rev,
    output logic [9:0] o_dx,
    output logic [9:0] o_dy
);

    logic [14:0] w_prod_x;
    logic [14:0] w_prod_y;
    logic        w_move;
    logic        w_neg_x;
    logic        w_neg_y;

    assign w_prod_x = {7'b0, i_step_q} * {8'b0, i_cos[6:0]};
    assign w_prod_y = {7'b0, i_step_q} * {8'b0, i_sin[6:0]};

    assign w_move  = i_fwd | i_rev;
    // Screen Y grows downward, so a positive sine moves the tank up when going forward.
    assign w_neg_x = i_fwd ? i_cos[7] : ~i_cos[7];
    assign w_neg_y = i_fwd ? ~i_sin[7] : i_sin[7];

    assign o_dx = w_move ? sm_to_tc(w_neg_x, w_prod_x[14:7]) : 10'd0;
    assign o_dy = w_move ? sm_to_tc(w_neg_y, w_prod_y[14:7]) : 10'd0;

endmodule

// File: rtl/tank_ctrl_multi.sv
// Per-player tank controller: motion, rotation, wall rollback, fire cooldown, lives and respawn.
// Define TANK_CTRL_SCREEN_CLAMP_EN to clamp position to the screen instead of wrapping mod 1024.
module tank_ctrl_multi
    import tank_pkg::*;
#(
    parameter int unsigned KEY_SLOTS      = 4,
    parameter int unsigned ANGLE_STEPS    = 45,
    parameter logic [7:0]  STEP_Q         = 8'd48,
    parameter logic [9:0]  X_CENTER       = 10'd300,
    parameter logic [9:0]  Y_CENTER       = 10'd250,
    parameter logic [9:0]  TANK_SIZE      = 10'd10,
    parameter logic [7:0]  KEY_FWD        = KEY_FWD_DEF,
    parameter logic [7:0]  KEY_REV        = KEY_REV_DEF,
    parameter logic [7:0]  KEY_CCW        = KEY_CCW_DEF,
    parameter logic [7:0]  KEY_CW         = KEY_CW_DEF,
    parameter logic [7:0]  KEY_FIRE       = KEY_FIRE_DEF,
    parameter int unsigned FIRE_COOLDOWN  = 16,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned LIVES          = 3
) (
    input  logic                           frame_clk,
    input  logic                           Reset_n,
    input  logic                           hit,
    input  logic                           isWallTop,
    input  logic                           isWallBottom,
    input  logic                           isWallLeft,
    input  logic                           isWallRight,
    input  logic [7:0]                     sin,
    input  logic [7:0]                     cos,
    input  logic [8*KEY_SLOTS-1:0]         keycode,
    output logic [9:0]                     TankX,
    output logic [9:0]                     TankY,
    output logic [9:0]                     TankS,
    output logic [9:0]                     TankXStep,
    output logic [9:0]                     TankYStep,
    output logic [$clog2(ANGLE_STEPS)-1:0] Angle,
    output logic                           ShootBullet,
    output logic                           Alive,
    output logic [2:0]                     Lives,
    output logic                           GameOver
);

    localparam int AW  = $clog2(ANGLE_STEPS);
    localparam int CDW = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
    localparam int RSW = (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;

    localparam logic [AW-1:0]  ANGLE_MAX     = AW'(ANGLE_STEPS - 1);
    localparam logic [CDW-1:0] COOLDOWN_INIT = CDW'(FIRE_COOLDOWN);
    localparam logic [RSW-1:0] RESPAWN_INIT  = RSW'(RESPAWN_FRAMES);
    localparam logic [2:0]     LIVES_INIT    = 3'(LIVES);

    tank_state_e    r_state,      w_state_d;
    logic [9:0]     r_x,          w_x_d;
    logic [9:0]     r_y,          w_y_d;
    logic [9:0]     r_prev_x,     w_prev_x_d;
    logic [9:0]     r_prev_y,     w_prev_y_d;
    logic [9:0]     r_xstep,      w_xstep_d;
    logic [9:0]     r_ystep,      w_ystep_d;
    logic [AW-1:0]  r_angle,      w_angle_d;
    logic           r_shoot,      w_shoot_d;
    logic [2:0]     r_lives,      w_lives_d;
    logic [CDW-1:0] r_cooldown,   w_cooldown_d;
    logic [RSW-1:0] r_respawn,    w_respawn_d;
    logic           r_fire_prev,  w_fire_prev_d;

    logic       w_key_fwd, w_key_rev, w_key_ccw, w_key_cw, w_key_fire;
    logic       w_fwd, w_rev, w_ccw, w_cw;
    logic       w_wall;
    logic       w_fire_edge;
    logic [9:0] w_dx, w_dy;
    logic [9:0] w_mv_x, w_mv_y;
    logic [9:0] w_mv_xstep, w_mv_ystep;

    always_comb begin
        w_key_fwd  = 1'b0;
        w_key_rev  = 1'b0;
        w_key_ccw  = 1'b0;
        w_key_cw   = 1'b0;
        w_key_fire = 1'b0;
        for (int i = 0; i < int'(KEY_SLOTS); i++) begin
            if (keycode[8*i +: 8] == KEY_FWD)  w_key_fwd  = 1'b1;
            if (keycode[8*i +: 8] == KEY_REV)  w_key_rev  = 1'b1;
            if (keycode[8*i +: 8] == KEY_CCW)  w_key_ccw  = 1'b1;
            if (keycode[8*i +: 8] == KEY_CW)   w_key_cw   = 1'b1;
            if (keycode[8*i +: 8] == KEY_FIRE) w_key_fire = 1'b1;
        end
    end

    // Only the highest-priority motion key acts in a frame.
    assign w_fwd = w_key_fwd;
    assign w_rev = ~w_key_fwd & w_key_rev;
    assign w_ccw = ~w_key_fwd & ~w_key_rev & w_key_ccw;
    assign w_cw  = ~w_key_fwd & ~w_key_rev & ~w_key_ccw & w_key_cw;

    assign w_wall      = isWallTop | isWallBottom | isWallLeft | isWallRight;
    assign w_fire_edge = w_key_fire & ~r_fire_prev;

    tank_step_calc u_step_calc (
        .i_sin    (sin),
        .i_cos    (cos),
        .i_step_q (STEP_Q),
        .i_fwd    (w_fwd),
        .i_rev    (w_rev),
        .o_dx     (w_dx),
        .o_dy     (w_dy)
    );

`ifdef TANK_CTRL_SCREEN_CLAMP_EN
    localparam logic signed [11:0] X_MAX = $signed({2'b00, SCREEN_W - 10'd1 - TANK_SIZE});
    localparam logic signed [11:0] Y_MAX = $signed({2'b00, SCREEN_H - 10'd1 - TANK_SIZE});

    function automatic logic [9:0] clamp_pos(input logic [9:0] pos, input logic [9:0] step,
                                             input logic signed [11:0] hi);
        logic signed [11:0] sum;
        sum = $signed({2'b00, pos}) + $signed({{2{step[9]}}, step});
        if (sum < 12'sd0) begin
            return 10'd0;
        end else if (sum > hi) begin
            return hi[9:0];
        end
        return sum[9:0];
    endfunction

    assign w_mv_x     = clamp_pos(r_x, w_dx, X_MAX);
    assign w_mv_y     = clamp_pos(r_y, w_dy, Y_MAX);
    assign w_mv_xstep = w_mv_x - r_x;
    assign w_mv_ystep = w_mv_y - r_y;
`else
    assign w_mv_x     = r_x + w_dx;
    assign w_mv_y     = r_y + w_dy;
    assign w_mv_xstep = w_dx;
    assign w_mv_ystep = w_dy;
`endif

    always_comb begin
        w_state_d     = r_state;
        w_x_d         = r_x;
        w_y_d         = r_y;
        w_prev_x_d    = r_prev_x;
        w_prev_y_d    = r_prev_y;
        w_xstep_d     = r_xstep;
        w_ystep_d     = r_ystep;
        w_angle_d     = r_angle;
        w_shoot_d     = 1'b0;
        w_lives_d     = r_lives;
        w_respawn_d   = r_respawn;
        w_fire_prev_d = w_key_fire;
        w_cooldown_d  = (r_cooldown != '0) ? r_cooldown - CDW'(1) : r_cooldown;

        unique case (r_state)
            StAlive: begin
                if (hit) begin
                    w_xstep_d = 10'd0;
                    w_ystep_d = 10'd0;
                    if (r_lives > 3'd1) begin
                        w_lives_d   = r_lives - 3'd1;
                        w_state_d   = StDead;
                        w_respawn_d = RESPAWN_INIT;
                    end else begin
                        w_lives_d = 3'd0;
                        w_state_d = StGameOver;
                    end
                end else begin
                    if (w_fire_edge && (r_cooldown == '0)) begin
                        w_shoot_d    = 1'b1;
                        w_cooldown_d = COOLDOWN_INIT;
                    end
                    if (w_wall) begin
                        w_x_d     = r_prev_x;
                        w_y_d     = r_prev_y;
                        w_xstep_d = 10'd0;
                        w_ystep_d = 10'd0;
                    end else begin
                        w_prev_x_d = r_x;
                        w_prev_y_d = r_y;
                        w_x_d      = w_mv_x;
                        w_y_d      = w_mv_y;
                        w_xstep_d  = w_mv_xstep;
                        w_ystep_d  = w_mv_ystep;
                        if (w_ccw) begin
                            w_angle_d = (r_angle == ANGLE_MAX) ? '0 : r_angle + AW'(1);
                        end else if (w_cw) begin
                            w_angle_d = (r_angle == '0) ? ANGLE_MAX : r_angle - AW'(1);
                        end
                    end
                end
            end
            StDead: begin
                w_xstep_d = 10'd0;
                w_ystep_d = 10'd0;
                // Respawn on the edge that would take the counter to zero: 60 dead frames total.
                if (r_respawn <= RSW'(1)) begin
                    w_state_d    = StAlive;
                    w_x_d        = X_CENTER;
                    w_y_d        = Y_CENTER;
                    w_prev_x_d   = X_CENTER;
                    w_prev_y_d   = Y_CENTER;
                    w_angle_d    = '0;
                    w_cooldown_d = '0;
                    w_respawn_d  = '0;
                end else begin
                    w_respawn_d = r_respawn - RSW'(1);
                end
            end
            StGameOver: begin
                w_cooldown_d  = r_cooldown;
                w_fire_prev_d = r_fire_prev;
            end
            default: begin
                w_state_d = StAlive;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            r_state     <= StAlive;
            r_x         <= X_CENTER;
            r_y         <= Y_CENTER;
            r_prev_x    <= X_CENTER;
            r_prev_y    <= Y_CENTER;
            r_xstep     <= 10'd0;
            r_ystep     <= 10'd0;
            r_angle     <= '0;
            r_shoot     <= 1'b0;
            r_lives     <= LIVES_INIT;
            r_cooldown  <= '0;
            r_respawn   <= '0;
            r_fire_prev <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_x         <= w_x_d;
            r_y         <= w_y_d;
            r_prev_x    <= w_prev_x_d;
            r_prev_y    <= w_prev_y_d;
            r_xstep     <= w_xstep_d;
            r_ystep     <= w_ystep_d;
            r_angle     <= w_angle_d;
            r_shoot     <= w_shoot_d;
            r_lives     <= w_lives_d;
            r_cooldown  <= w_cooldown_d;
            r_respawn   <= w_respawn_d;
            r_fire_prev <= w_fire_prev_d;
        end
    end

    assign TankX       = r_x;
    assign TankY       = r_y;
    assign TankS       = TANK_SIZE;
    assign TankXStep   = r_xstep;
    assign TankYStep   = r_ystep;
    assign Angle       = r_angle;
    assign ShootBullet = r_shoot;
    assign Alive       = (r_state == StAlive);
    assign Lives       = r_lives;
    assign GameOver    = (r_state == StGameOver);

endmodule

// File: tb/tb_tank_ctrl_multi.sv
// Directed-vector bench for tank_ctrl_multi; expectations are tagged with the edge they apply to.
module tb_tank_ctrl_multi;

    localparam int F_X = 0, F_Y = 1, F_XS = 2, F_YS = 3, F_ANG = 4;
    localparam int F_SHOOT = 5, F_ALIVE = 6, F_LIVES = 7, F_GO = 8, F_S = 9;

    localparam logic [7:0] K_FWD  = 8'h52;
    localparam logic [7:0] K_REV  = 8'h51;
    localparam logic [7:0] K_CCW  = 8'h50;
    localparam logic [7:0] K_CW   = 8'h4f;
    localparam logic [7:0] K_FIRE = 8'h2c;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hit;
    logic        wt, wb, wl, wr;
    logic [7:0]  sin_i, cos_i;
    logic [31:0] kc;

    logic [9:0]  tank_x, tank_y, tank_s, tank_xs, tank_ys;
    logic [5:0]  ang;
    logic        shoot, alive, game_over;
    logic [2:0]  lives;

    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;
    int    q_tag[$];
    int    q_fld[$];
    int    q_val[$];
    string q_name[$];

    tank_ctrl_multi dut (
        .frame_clk    (clk),
        .Reset_n      (rst_n),
        .hit          (hit),
        .isWallTop    (wt),
        .isWallBottom (wb),
        .isWallLeft   (wl),
        .isWallRight  (wr),
        .sin          (sin_i),
        .cos          (cos_i),
        .keycode      (kc),
        .TankX        (tank_x),
        .TankY        (tank_y),
        .TankS        (tank_s),
        .TankXStep    (tank_xs),
        .TankYStep    (tank_ys),
        .Angle        (ang),
        .ShootBullet  (shoot),
        .Alive        (alive),
        .Lives        (lives),
        .GameOver     (game_over)
    );

    always #5 clk = ~clk;

    // Expectation for the state after the next rising edge.
    function automatic void ex(input int f, input int v, input string n);
        q_tag.push_back(cyc + 1);
        q_fld.push_back(f);
        q_val.push_back(v);
        q_name.push_back(n);
    endfunction

    function automatic void ex_reset(input string n);
        ex(F_X, 300, n);     ex(F_Y, 250, n);   ex(F_XS, 0, n);    ex(F_YS, 0, n);
        ex(F_ANG, 0, n);     ex(F_SHOOT, 0, n); ex(F_ALIVE, 1, n); ex(F_LIVES, 3, n);
        ex(F_GO, 0, n);      ex(F_S, 10, n);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: after each edge, retire every expectation tagged for that edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q_tag.size() > 0 && q_tag[0] <= cyc) begin
                int    act;
                int    t;
                int    f;
                int    v;
                string n;
                t = q_tag.pop_front();
                f = q_fld.pop_front();
                v = q_val.pop_front();
                n = q_name.pop_front();
                case (f)
                    F_X:     act = int'(tank_x);
                    F_Y:     act = int'(tank_y);
                    F_XS:    act = int'(tank_xs);
                    F_YS:    act = int'(tank_ys);
                    F_ANG:   act = int'(ang);
                    F_SHOOT: act = int'(shoot);
                    F_ALIVE: act = int'(alive);
                    F_LIVES: act = int'(lives);
                    F_GO:    act = int'(game_over);
                    default: act = int'(tank_s);
                endcase
                total++;
                if (act != v || t != cyc) begin
                    bad++;
                    $display("FAIL %s field=%0d edge=%0d got=%0d want=%0d", n, f, cyc, act, v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; hit = 1'b0; wt = 1'b0; wb = 1'b0; wl = 1'b0; wr = 1'b0;
        sin_i = 8'h00; cos_i = 8'h7f; kc = 32'h0;
        ex_reset("reset"); step();
        kc = {24'h0, K_FWD}; hit = 1'b1;
        ex_reset("reset_dominates"); step();
        rst_n = 1'b1; hit = 1'b0;

        // Forward along +X: dx = (48*127)>>7 = 47.
        for (int i = 1; i <= 3; i++) begin
            ex(F_X, 300 + 47 * i, "fwd_x"); ex(F_Y, 250, "fwd_y");
            ex(F_XS, 47, "fwd_xs");          ex(F_YS, 0, "fwd_ys");
            step();
        end
        kc = {K_FWD, 24'h0};
        ex(F_X, 488, "fwd_slot3"); step();

        // Wall rolls back to the position saved before the last legal step.
        wr = 1'b1;
        ex(F_X, 441, "wall_x"); ex(F_XS, 0, "wall_xs"); ex(F_YS, 0, "wall_ys"); step();
        ex(F_X, 441, "wall_hold"); step();
        wr = 1'b0;

        // Reverse with sin=+127: Y increases by 47.
        kc = {24'h0, K_REV}; cos_i = 8'h00; sin_i = 8'h7f;
        ex(F_Y, 297, "rev_y"); ex(F_YS, 47, "rev_ys"); ex(F_X, 441, "rev_x"); ex(F_XS, 0, "rev_xs");
        step();

        // Forward with cos=-64 (dx=24) and sin=-127 (dy=47).
        kc = {24'h0, K_FWD}; cos_i = 8'hc0; sin_i = 8'hff;
        ex(F_X, 417, "neg_x"); ex(F_XS, 1000, "neg_xs"); ex(F_Y, 344, "neg_y"); ex(F_YS, 47, "neg_ys");
        step();

        cos_i = 8'h00; sin_i = 8'h00;
        kc = {24'h0, K_CW};
        ex(F_ANG, 44, "cw_wrap"); step();
        ex(F_ANG, 43, "cw_dec");  step();
        kc = {24'h0, K_CCW};
        ex(F_ANG, 44, "ccw_inc");  step();
        ex(F_ANG, 0, "ccw_wrap");  step();
        ex(F_ANG, 1, "ccw_inc2");  step();
        kc = {16'h0, K_CW, K_FWD};
        ex(F_ANG, 1, "prio_fwd_ang"); ex(F_X, 417, "prio_fwd_x"); step();
        kc = {24'h0, K_CCW}; wt = 1'b1;
        ex(F_ANG, 1, "wall_rot"); ex(F_X, 417, "wall_rot_x"); ex(F_Y, 344, "wall_rot_y"); step();
        wt = 1'b0;

        // Fire: edge-triggered, one pulse per press, cooldown of 16 frames.
        kc = {16'h0, K_FIRE, 8'h0};
        for (int i = 0; i < 40; i++) begin
            ex(F_SHOOT, (i == 0) ? 1 : 0, "fire_hold"); step();
        end
        kc = 32'h0; ex(F_SHOOT, 0, "fire_release"); step();
        kc = {24'h0, K_FIRE}; ex(F_SHOOT, 1, "fire_repress"); step();
        for (int k = 1; k <= 17; k++) begin
            kc = (k == 5 || k == 17) ? {24'h0, K_FIRE} : 32'h0;
            if (k == 5) ex(F_SHOOT, 0, "fire_cooldown_block");
            else if (k == 17) ex(F_SHOOT, 1, "fire_cooldown_done");
            else ex(F_SHOOT, 0, "fire_idle");
            step();
        end
        kc = 32'h0; step();

        // First hit: lose a life, dead for 60 frames, respawn at center.
        kc = {24'h0, K_FWD}; cos_i = 8'h7f; hit = 1'b1;
        ex(F_LIVES, 2, "hit1_lives"); ex(F_ALIVE, 0, "hit1_alive"); ex(F_X, 417, "hit1_x");
        ex(F_XS, 0, "hit1_xs"); step();
        for (int k = 1; k <= 59; k++) begin
            hit = (k == 10);
            ex(F_ALIVE, 0, "dead_alive");
            if (k == 10) ex(F_LIVES, 2, "dead_hit_ignored");
            if (k == 59) ex(F_X, 417, "dead_x_held");
            step();
        end
        hit = 1'b0;
        ex(F_ALIVE, 1, "respawn_alive"); ex(F_X, 300, "respawn_x"); ex(F_Y, 250, "respawn_y");
        ex(F_ANG, 0, "respawn_ang"); step();
        ex(F_X, 347, "post_respawn_x"); ex(F_XS, 47, "post_respawn_xs"); step();

        kc = 32'h0; hit = 1'b1;
        ex(F_LIVES, 1, "hit2_lives"); ex(F_ALIVE, 0, "hit2_alive"); step();
        hit = 1'b0;
        for (int k = 1; k <= 59; k++) step();
        ex(F_ALIVE, 1, "respawn2_alive"); ex(F_X, 300, "respawn2_x"); step();

        hit = 1'b1;
        ex(F_LIVES, 0, "hit3_lives"); ex(F_GO, 1, "hit3_go"); ex(F_ALIVE, 0, "hit3_alive"); step();
        kc = {K_FIRE, K_CW, 8'h0, K_FWD};
        for (int k = 0; k < 3; k++) begin
            hit = (k == 1);
            ex(F_X, 300, "go_x"); ex(F_ANG, 0, "go_ang"); ex(F_SHOOT, 0, "go_shoot");
            ex(F_GO, 1, "go_flag"); ex(F_LIVES, 0, "go_lives");
            step();
        end
        hit = 1'b0; kc = 32'h0;

        rst_n = 1'b0; ex_reset("reset_from_go"); step();
        rst_n = 1'b1; hit = 1'b1;
        ex(F_LIVES, 2, "hit4_lives"); ex(F_ALIVE, 0, "hit4_alive"); step();
        hit = 1'b0;
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0; hit = 1'b1; kc = {24'h0, K_FWD};
        ex_reset("reset_mid_dead"); step();
        rst_n = 1'b1; hit = 1'b0;

        for (int i = 1; i <= 7; i++) begin
            ex(F_X, 300 + 47 * i, "run_x"); step();
        end
`ifdef TANK_CTRL_SCREEN_CLAMP_EN
        ex(F_X, 629, "clamp_x"); ex(F_XS, 0, "clamp_xs"); step();
`else
        ex(F_X, 676, "wrap_x"); ex(F_XS, 47, "wrap_xs"); step();
`endif
        kc = 32'h0;
        step();
        step();

        total++;
        if (q_tag.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations got=%0d want=0", q_tag.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tank_ctrl_multi.md
# tank_ctrl_multi

Parametrised successor to the single-player tank controller. One instance per player. Each instance turns that player's USB keycode bytes into tank position, heading, per-frame motion and bullet-fire requests. It adds the following over the previous generation:

- configurable key map, speed, heading resolution and spawn point;
- edge-triggered fire with a cooldown;
- a lives counter with a respawn delay and a game-over state;
- true wall rollback to the last legal position.

## Interface
Parameters:
- KEY_SLOTS, 4: number of keycode bytes in `keycode`
- ANGLE_STEPS, 45: headings per revolution (0 .. ANGLE_STEPS-1)
- STEP_Q, 8'd48: forward speed, unsigned; pixel displacement = (STEP_Q*mag)>>7
- X_CENTER, 10'd300 / Y_CENTER, 10'd250: spawn position
- TANK_SIZE, 10'd10: reported size
- KEY_FWD 8'h52, KEY_REV 8'h51, KEY_CCW 8'h50, KEY_CW 8'h4f, KEY_FIRE 8'h2c
- FIRE_COOLDOWN, 16: frames between shots
- RESPAWN_FRAMES, 60: frames spent in DEAD
- LIVES, 3: initial lives (1..7)

Ports:
- frame_clk  in  1  sole clock, one edge per video frame
- Reset_n  in  1  synchronous, active-low reset
- hit  in  1  bullet struck this tank, sampled each edge
- isWallTop, isWallBottom, isWallLeft, isWallRight  in  1 each  current position overlaps a wall
- sin, cos  in  8  sign-magnitude heading: bit7 = sign, [6:0] = magnitude/128
- keycode  in  8*KEY_SLOTS  pressed-key bytes, 8'h00 = empty slot
- TankX, TankY  out  10  position
- TankS  out  10  constant TANK_SIZE
- TankXStep, TankYStep  out  10  two's-complement displacement applied this frame
- Angle  out  $clog2(ANGLE_STEPS)  heading index
- ShootBullet  out  1  one-cycle fire pulse
- Alive  out  1  tank is drawable and collidable
- Lives  out  3  remaining lives
- GameOver  out  1  lives exhausted

## Operation
Key decode: a key is pressed if any slot equals its code. Motion priority is FWD > REV > CCW > CW. Fire is independent of motion.

Displacement:
- dx = (STEP_Q*cos[6:0])>>7, dy = (STEP_Q*sin[6:0])>>7, each 8 bits, zero-extended to 10.
- FWD: X += ±dx with sign = cos[7]; Y -= ±dy with sign = sin[7] (screen Y grows downward).
- REV: negation of the FWD displacements.
- No motion key: both steps are 0.

Rotation:
- CCW: Angle+1, wrapping ANGLE_STEPS-1 → 0.
- CW: Angle-1, wrapping 0 → ANGLE_STEPS-1.
- Exactly one step per frame while the key is held.

Walls: if any isWall* is high on an edge, the position is restored to the saved previous position, both steps go to 0, and the angle is held. The previous position is saved only on edges with no wall flag.

Fire:
- ShootBullet pulses when the fire key goes from released to pressed, and only when cooldown = 0 and state = ALIVE.
- The pulse loads cooldown with FIRE_COOLDOWN, which then decrements each frame.
- Holding the key never refires.

State machine:
- ALIVE: normal operation.
  - On hit with Lives>1: Lives-1, go to DEAD, respawn counter = RESPAWN_FRAMES.
  - On hit with Lives==1: Lives = 0, go to GAME_OVER.
- DEAD: Alive = 0, steps = 0, keys ignored, the counter decrements. At counter 0: position = center, Angle = 0, cooldown = 0, go to ALIVE.
- GAME_OVER: Alive = 0, GameOver = 1, all outputs frozen. Only reset leaves this state.

Simultaneous events:
- hit beats wall, motion and fire.
- hit in DEAD or GAME_OVER is ignored.
- wall beats motion, but rotation is also suppressed.
- A fire press in the same edge as a wall flag still fires.

## Timing
- All outputs are registered and change only on a frame_clk edge.
- Latency from a keycode change to a new TankX/TankY/Angle is 1 edge. The wall-flag response is also 1 edge.
- ShootBullet is high for exactly 1 cycle.
- Reset (Reset_n low at an edge, including mid-DEAD or mid-cooldown) sets the following. Reset dominates all other inputs.
  - TankX = X_CENTER, TankY = Y_CENTER
  - TankXStep = 0, TankYStep = 0, Angle = 0
  - ShootBullet = 0, Alive = 1, Lives = LIVES, GameOver = 0
  - cooldown = 0, state = ALIVE, previous fire-key level = 0
- Position arithmetic is 10-bit.

## Configuration
- TANK_CTRL_SCREEN_CLAMP_EN defined: the next position is clamped to X 0..639-TANK_SIZE and Y 0..479-TANK_SIZE. The reported step is the clamped difference.
- Not defined: position wraps modulo 1024 and steps are reported unclamped.

## Structure
- Package tank_pkg holds:
  - the state enum (ALIVE, DEAD, GAME_OVER);
  - default key-code constants;
  - screen bounds 640/480;
  - a function converting sign-magnitude plus an 8-bit magnitude into a 10-bit two's-complement value.
- Sub-module tank_step_calc is purely combinational. It takes sin, cos, STEP_Q and the direction, and produces the 10-bit dx/dy.

## Test plan
- Reset, then FWD held with cos = 8'h7f, sin = 8'h00 → TankX = 300, 347, 394, … (dx = 47); TankY fixed at 250.
- CW held from Angle 0 → Angle 44 on edge 1, 43 on edge 2. CCW held at 44 → 0.
- FWD on one edge, then isWallRight = 1 on the next → TankX back to the pre-step value and steps = 0.
- Fire held for 40 frames → exactly 1 pulse. Release, then re-press at frame 5 after the pulse → no pulse. Re-press after 16 frames → pulse.
- hit with Lives = 3 → Lives = 2, Alive = 0 for 60 frames, then center / Angle 0. Third hit → GameOver = 1, and keys have no effect.
- Reset_n low mid-DEAD → the next edge shows all reset values. Repeat with the macro defined and FWD at X = 625 → TankX saturates at 629.
